// File: rtl/mem_port_arbiter_if.sv
// Requester and BRAM signal bundle for the
// shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;

  logic          i_ls_req;
  logic          i_ls_we;
  logic [AW-1:0] i_ls_addr;
  logic [DW-1:0] i_ls_wdata;
  logic          o_ls_gnt;
  logic          o_ls_rvalid;
  logic [DW-1:0] o_ls_rdata;

  logic          o_mem_rd;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  logic          o_busy;

  modport slave (
    input  i_if_req,
    input  i_if_addr,
    output o_if_gnt,
    output o_if_rvalid,
    output o_if_rdata,
    input  i_ls_req,
    input  i_ls_we,
    input  i_ls_addr,
    input  i_ls_wdata,
    output o_ls_gnt,
    output o_ls_rvalid,
    output o_ls_rdata,
    output o_mem_rd,
    output o_mem_we,
    output o_mem_addr,
    output o_mem_wdata,
    input  i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req,
    output i_if_addr,
    input  o_if_gnt,
    input  o_if_rvalid,
    input  o_if_rdata,
    output i_ls_req,
    output i_ls_we,
    output i_ls_addr,
    output i_ls_wdata,
    input  o_ls_gnt,
    input  o_ls_rvalid,
    input  o_ls_rdata,
    input  o_mem_rd,
    input  o_mem_we,
    input  o_mem_addr,
    input  o_mem_wdata,
    output i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported
// BRAM between instruction fetch and load/store.
module mem_port_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef struct packed {
    state_t        state;
    logic          rr_last;
    logic          owner;
    logic          busy;
    logic          if_gnt;
    logic          ls_gnt;
    logic          if_rvalid;
    logic          ls_rvalid;
    logic          mem_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] ls_rdata;
  } regs_t;

  localparam logic SIDE_IF = 1'b0;
  localparam logic SIDE_LS = 1'b1;

  regs_t r;
  regs_t n;
  logic  both;
  logic  ls_only;
  logic  win;
  logic  wr;

  // Winner pick: on contention the side that lost last time goes.
  always_comb begin
    both    = bus.i_if_req & bus.i_ls_req;
    ls_only = bus.i_ls_req & ~bus.i_if_req;
    win     = SIDE_IF;
    unique case (1'b1)
      both:    win = ~r.rr_last;
      ls_only: win = SIDE_LS;
      default: win = SIDE_IF;
    endcase
    wr = win & bus.i_ls_we;
  end

  // Next-state and next registered-output values.
  always_comb begin
    n           = r;
    n.if_gnt    = 1'b0;
    n.ls_gnt    = 1'b0;
    n.if_rvalid = 1'b0;
    n.ls_rvalid = 1'b0;
    unique case (r.state)
      S_IDLE: begin
        if (bus.i_if_req | bus.i_ls_req) begin
          n.state    = S_ISSUE;
          n.rr_last  = win;
          n.owner    = win;
          n.if_gnt   = ~win;
          n.ls_gnt   = win;
          n.mem_we   = wr;
          n.mem_rd   = ~wr;
          n.mem_addr = win ? bus.i_ls_addr
                           : bus.i_if_addr;
          if (win) begin
            n.mem_wdata = bus.i_ls_wdata;
          end
        end
      end
      S_ISSUE: begin
        n.mem_rd = 1'b0;
        n.mem_we = 1'b0;
        n.state  = r.mem_rd ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        n.state = S_IDLE;
        if (r.owner) begin
          n.ls_rdata  = bus.i_mem_rdata;
          n.ls_rvalid = 1'b1;
        end else begin
          n.if_rdata  = bus.i_mem_rdata;
          n.if_rvalid = 1'b1;
        end
      end
      default: n.state = S_IDLE;
    endcase
    n.busy = (n.state != S_IDLE);
  end

  // State and output registers; reset drops any in-flight read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r         <= '0;
      r.rr_last <= SIDE_LS;
    end else begin
      r <= n;
    end
  end

  assign bus.o_if_gnt    = r.if_gnt;
  assign bus.o_if_rvalid = r.if_rvalid;
  assign bus.o_if_rdata  = r.if_rdata;
  assign bus.o_ls_gnt    = r.ls_gnt;
  assign bus.o_ls_rvalid = r.ls_rvalid;
  assign bus.o_ls_rdata  = r.ls_rdata;
  assign bus.o_mem_rd    = r.mem_rd;
  assign bus.o_mem_we    = r.mem_we;
  assign bus.o_mem_addr  = r.mem_addr;
  assign bus.o_mem_wdata = r.mem_wdata;
  assign bus.o_busy      = r.busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed
// scenarios plus randomized IF/LS traffic.
module tb_mem_port_arbiter;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Environment BRAM: one-cycle read latency.
  logic [DW-1:0] bram [DEPTH];
  bit            bram_filled = 1'b0;
  always @(posedge clk) begin
    if (!bram_filled) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_val(i);
      bram_filled <= 1'b1;
    end else begin
      if (bus.o_mem_we) bram[bus.o_mem_addr] <= bus.o_mem_wdata;
      if (bus.o_mem_rd) bus.i_mem_rdata <= bram[bus.o_mem_addr];
    end
  end

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string got,
                      input string want);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected %s", name, got, want);
  endtask

  function automatic logic [127:0] outs();
    return {11'd0, bus.o_if_gnt, bus.o_if_rvalid, bus.o_if_rdata,
            bus.o_ls_gnt, bus.o_ls_rvalid, bus.o_ls_rdata,
            bus.o_mem_rd, bus.o_mem_we, bus.o_mem_addr,
            bus.o_mem_wdata, bus.o_busy};
  endfunction

  // Reference model state and scoreboard queues.
  typedef struct {
    int            cyc;
    bit            side;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic [DW-1:0] ref_mem [DEPTH];
  ev_t gnt_q[$];
  ev_t rv_q[$];
  bit  last_ls;
  int  avail;
  int  bfrom;
  bit  order_log[$];

  initial begin : scoreboard
    ev_t           e;
    bit            ls;
    bit            we;
    bit            exp_busy;
    logic [AW-1:0] a;
    logic [DW-1:0] got;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    last_ls = 1'b1;
    avail   = 0;
    bfrom   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt_q.delete();
        rv_q.delete();
        last_ls = 1'b1;
        avail   = 0;
        bfrom   = 0;
        check("reset_outs", outs(), '0);
      end else begin
        exp_busy = (cyc >= bfrom) && (cyc < avail);
        check("busy", bus.o_busy, exp_busy);
        check("gnt_excl", bus.o_if_gnt & bus.o_ls_gnt, 0);
        check("rvalid_excl", bus.o_if_rvalid & bus.o_ls_rvalid, 0);
        check("rd_we_excl", bus.o_mem_rd & bus.o_mem_we, 0);
        if (bus.o_if_gnt || bus.o_ls_gnt) begin
          if (gnt_q.size() == 0) begin
            flag("gnt_unexpected", "grant", "no grant");
          end else begin
            e = gnt_q.pop_front();
            check("gnt_cyc", cyc, e.cyc);
            check("gnt_side", bus.o_ls_gnt, e.side);
            check("mem_addr", bus.o_mem_addr, e.addr);
            check("mem_we", bus.o_mem_we, e.we);
            check("mem_rd", bus.o_mem_rd, !e.we);
            if (e.we) check("mem_wdata", bus.o_mem_wdata, e.data);
          end
        end else if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
          void'(gnt_q.pop_front());
          flag("gnt_missing", "no grant", "grant");
        end
        if (bus.o_if_rvalid || bus.o_ls_rvalid) begin
          if (rv_q.size() == 0) begin
            flag("rvalid_unexpected", "rvalid", "no rvalid");
          end else begin
            e = rv_q.pop_front();
            got = bus.o_ls_rvalid ? bus.o_ls_rdata : bus.o_if_rdata;
            check("rv_cyc", cyc, e.cyc);
            check("rv_side", bus.o_ls_rvalid, e.side);
            check("rv_data", got, e.data);
          end
        end else if (rv_q.size() > 0 && rv_q[0].cyc <= cyc) begin
          void'(rv_q.pop_front());
          flag("rvalid_missing", "no rvalid", "rvalid");
        end
        // Arbitration happens at the coming edge once the port is free.
        if (cyc >= avail && (bus.i_if_req || bus.i_ls_req)) begin
          if (bus.i_if_req && bus.i_ls_req) ls = !last_ls;
          else ls = bus.i_ls_req;
          last_ls = ls;
          we = ls && bus.i_ls_we;
          a  = ls ? bus.i_ls_addr : bus.i_if_addr;
          e.cyc  = cyc + 1;
          e.side = ls;
          e.we   = we;
          e.addr = a;
          e.data = we ? bus.i_ls_wdata : ref_mem[a];
          gnt_q.push_back(e);
          bfrom = cyc + 1;
          if (we) begin
            ref_mem[a] = bus.i_ls_wdata;
            avail = cyc + 2;
          end else begin
            e.cyc = cyc + 3;
            rv_q.push_back(e);
            avail = cyc + 3;
          end
        end
      end
    end
  end

  task automatic wait_gnt(input bit ls);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      got = ls ? bus.o_ls_gnt : bus.o_if_gnt;
    end
    if (got) order_log.push_back(ls);
    else flag("gnt_timeout", "no grant in 40 cycles", "grant");
  endtask

  task automatic if_read(input logic [AW-1:0] a, output int gc);
    bus.i_if_addr = a;
    bus.i_if_req  = 1'b1;
    wait_gnt(1'b0);
    bus.i_if_req = 1'b0;
    gc = cyc;
  endtask

  task automatic ls_op(input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int gc);
    bus.i_ls_we    = we;
    bus.i_ls_addr  = a;
    bus.i_ls_wdata = d;
    bus.i_ls_req   = 1'b1;
    wait_gnt(1'b1);
    bus.i_ls_req = 1'b0;
    gc = cyc;
  endtask

  task automatic gap(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return {AW{1'b1}};
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int s;
    int g;
    int g2;
    int same;
    int pack;
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = '0;
    bus.i_ls_req   = 1'b0;
    bus.i_ls_we    = 1'b0;
    bus.i_ls_addr  = '0;
    bus.i_ls_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_busy", bus.o_busy, 0);

    // IF-only read of preloaded word.
    s = cyc;
    if_read(14'h0005, g);
    check("t1_gnt_lat", g - s, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t1_rvalid", bus.o_if_rvalid, 1);
    check("t1_rdata", bus.o_if_rdata, 32'hDEADBEEF);

    // LS write then read-back.
    s = cyc;
    ls_op(1'b1, 14'h0010, 32'h12345678, g);
    check("t2_wr_gnt", g - s, 1);
    ls_op(1'b0, 14'h0010, 32'h0, g2);
    check("t2_rd_gnt", g2 - s, 3);
    repeat (2) @(posedge clk);
    #1;
    check("t2_rvalid", bus.o_ls_rvalid, 1);
    check("t2_rdata", bus.o_ls_rdata, 32'h12345678);

    // Both requesting from reset.
    do_reset();
    order_log.delete();
    fork
      begin
        int gi;
        repeat (2) if_read(rand_addr(), gi);
      end
      begin
        int gl;
        repeat (2) ls_op(1'b0, rand_addr(), 32'h0, gl);
      end
    join
    pack = 0;
    foreach (order_log[i]) pack = (pack << 1) | int'(order_log[i]);
    check("t3_order", pack, 4'b0101);

    // LS held continuously, IF requesting every cycle.
    order_log.delete();
    fork
      begin
        int gi;
        repeat (8) if_read(rand_addr(), gi);
      end
      begin
        int gl;
        repeat (8) ls_op(1'($urandom), rand_addr(), $urandom, gl);
      end
    join
    same = 0;
    for (int i = 1; i < order_log.size(); i++)
      if (order_log[i] == order_log[i-1]) same++;
    check("t4_alternate", same, 0);
    check("t4_count", order_log.size(), 16);

    // Reset while a read is in WAIT.
    gap(4);
    ls_op(1'b0, 14'h0007, 32'h0, g);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_async_clear", outs(), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s = cyc;
    if_read(14'h0003, g);
    check("t5_regrant", g - s, 1);

    // Request raised during ISSUE waits for IDLE.
    gap(4);
    if_read(14'h0014, g);
    check("t6_busy_issue", bus.o_busy, 1);
    ls_op(1'b0, 14'h0015, 32'h0, g2);
    check("t6_wait_gnt", g2 - g, 3);

    // Randomized mixed traffic.
    fork
      begin
        int gi;
        for (int i = 0; i < 30; i++) begin
          gap($urandom_range(0, 3));
          if_read(rand_addr(), gi);
        end
      end
      begin
        int gl;
        for (int i = 0; i < 30; i++) begin
          gap($urandom_range(0, 3));
          ls_op(1'($urandom), rand_addr(), $urandom, gl);
        end
      end
    join

    repeat (10) @(posedge clk);
    #1;
    check("sb_drain", gnt_q.size() + rv_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
